// File: rtl/seqgen_pkg.sv
// seqgen_pkg: shared definitions for the serial pattern transmitter.
//   - default sizing parameters for the pattern, length, repeat and gap fields
//   - state encoding for the transmitter FSM
package seqgen_pkg;

  localparam int SEQGEN_MAX_LEN = 16;
  localparam int SEQGEN_LEN_W   = 5;
  localparam int SEQGEN_REP_W   = 4;
  localparam int SEQGEN_GAP_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/seqgen_shreg.sv
// seqgen_shreg: loadable MSB-first shift register.
// The register stores the pattern already advanced by one position, so that
// sout always presents the bit the transmitter must drive at the next edge:
//   - during a load, sout is din[len-1] (the pattern's first bit)
//   - afterwards, sout is data[len_q-1], moving one bit per shift
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   load      capture din/len (takes priority over shift)
//   shift     advance the stored pattern by one bit
//   din       pattern to load
//   len       pattern length used for the load, 1..MAX_LEN
//   sout      next serial bit to transmit
module seqgen_shreg #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [MAX_LEN-1:0] din,
  input  logic [LEN_W-1:0]   len,
  output logic               sout
);

  localparam int IDX_W = $clog2(MAX_LEN);

  logic [MAX_LEN-1:0] data;
  logic [LEN_W-1:0]   len_q;
  logic [IDX_W-1:0]   idx;

  // The length only matters as an index; legal lengths keep len-1 in range.
  always_comb begin
    idx  = IDX_W'((load ? len : len_q) - LEN_W'(1));
    sout = load ? din[idx] : data[idx];
  end

  // Storing din<<1 on load means the first bit leaves straight from din.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      len_q <= '0;
    end else if (load) begin
      data  <= din << 1;
      len_q <= len;
    end else if (shift) begin
      data  <= data << 1;
    end
  end

endmodule

// File: rtl/seqgen.sv
// seqgen: serial pattern transmitter.
// Shifts a latched pattern out MSB-first, repeating it a programmed number of
// times with an optional idle gap between repetitions.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   start     transmission request, only honoured in IDLE
//   pat       pattern; bit pat_len-1 goes first
//   pat_len   pattern length, legal 1..MAX_LEN
//   rep       number of transmissions (0 behaves as 1)
//   gap       idle cycles between repetitions
//   prtx      serial data (0 when prtx_vld is low)
//   prtx_vld  prtx carries a pattern bit
//   busy      transmitter in SEND or GAP
//   done      one-cycle pulse after the final bit
//   err       one-cycle pulse for a start rejected on pat_len
module seqgen
  import seqgen_pkg::*;
#(
  parameter int MAX_LEN = SEQGEN_MAX_LEN,
  parameter int LEN_W   = SEQGEN_LEN_W,
  parameter int REP_W   = SEQGEN_REP_W,
  parameter int GAP_W   = SEQGEN_GAP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic [REP_W-1:0]   rep,
  input  logic [GAP_W-1:0]   gap,
  output logic               prtx,
  output logic               prtx_vld,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t state, state_n;

  logic [MAX_LEN-1:0] pat_q, pat_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [GAP_W-1:0]   gap_q, gap_n;
  logic [LEN_W-1:0]   bit_cnt, bit_cnt_n;
  logic [REP_W-1:0]   rep_cnt, rep_cnt_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;

  logic               prtx_n, vld_n, busy_n, done_n, err_n;
  logic               load, shift, sout;
  logic [MAX_LEN-1:0] sh_din;
  logic [LEN_W-1:0]   sh_len;
  logic               len_ok;
  logic [REP_W-1:0]   rep_eff;

  seqgen_shreg #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_shreg (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .shift(shift),
    .din  (sh_din),
    .len  (sh_len),
    .sout (sout)
  );

  assign len_ok  = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));
  assign rep_eff = (rep == '0) ? REP_W'(1) : rep;

  // bit_cnt counts the bits of the current repetition still on the line,
  // including the one being driven now; rep_cnt likewise counts repetitions
  // including the current one. Output values are computed one cycle ahead
  // so that every output leaves a flop.
  always_comb begin
    state_n   = state;
    pat_n     = pat_q;
    len_n     = len_q;
    gap_n     = gap_q;
    bit_cnt_n = bit_cnt;
    rep_cnt_n = rep_cnt;
    gap_cnt_n = gap_cnt;
    load      = 1'b0;
    shift     = 1'b0;
    sh_din    = pat_q;
    sh_len    = len_q;
    prtx_n    = 1'b0;
    vld_n     = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            pat_n     = pat;
            len_n     = pat_len;
            gap_n     = gap;
            rep_cnt_n = rep_eff;
            bit_cnt_n = pat_len;
            load      = 1'b1;
            sh_din    = pat;
            sh_len    = pat_len;
            prtx_n    = sout;
            vld_n     = 1'b1;
            busy_n    = 1'b1;
            state_n   = SEND;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      SEND: begin
        if (bit_cnt > LEN_W'(1)) begin
          shift     = 1'b1;
          prtx_n    = sout;
          vld_n     = 1'b1;
          busy_n    = 1'b1;
          bit_cnt_n = bit_cnt - LEN_W'(1);
        end else if (rep_cnt > REP_W'(1)) begin
          rep_cnt_n = rep_cnt - REP_W'(1);
          busy_n    = 1'b1;
          if (gap_q != '0) begin
            gap_cnt_n = gap_q;
            state_n   = GAP;
          end else begin
            load      = 1'b1;
            prtx_n    = sout;
            vld_n     = 1'b1;
            bit_cnt_n = len_q;
          end
        end else begin
          bit_cnt_n = '0;
          rep_cnt_n = '0;
          done_n    = 1'b1;
          state_n   = IDLE;
        end
      end

      GAP: begin
        busy_n = 1'b1;
        if (gap_cnt > GAP_W'(1)) begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end else begin
          gap_cnt_n = '0;
          load      = 1'b1;
          prtx_n    = sout;
          vld_n     = 1'b1;
          bit_cnt_n = len_q;
          state_n   = SEND;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State, latched request fields, counters and output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      gap_q    <= '0;
      bit_cnt  <= '0;
      rep_cnt  <= '0;
      gap_cnt  <= '0;
      prtx     <= 1'b0;
      prtx_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      pat_q    <= pat_n;
      len_q    <= len_n;
      gap_q    <= gap_n;
      bit_cnt  <= bit_cnt_n;
      rep_cnt  <= rep_cnt_n;
      gap_cnt  <= gap_cnt_n;
      prtx     <= prtx_n;
      prtx_vld <= vld_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

endmodule
